// File: rtl/xbar2x2_top_if.sv
// Shared types and the top-level bus for the 2x2 crossbar memory subsystem.
//
// pkg_mst : master command record (vld, cmd 1=WR/0=RD, addr, data)
// pkg_slv : slave read-data record
// pkg_st  : per-master transaction state
//
// xbar2x2_top_if groups the per-master command strobes and commands (driven
// by the environment) with the per-master state and read-result buffers
// (driven by the subsystem).
//   en[1:0]      per-master command strobe
//   in_mst[2]    per-master command
//   st[2]        per-master state, ADDR = idle/ready
//   buff0/buff1  8 x 32b read-result buffers of master 0 / master 1

package pkg_mst;
    typedef struct packed {
        logic        vld;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } t_mst;
endpackage

package pkg_slv;
    typedef struct packed {
        logic [31:0] data;
    } t_slv;
endpackage

package pkg_st;
    typedef enum logic [1:0] {ADDR, REQ, DATA, RESP} t_st;
endpackage

interface xbar2x2_top_if;
    logic [1:0]       en;
    pkg_mst::t_mst    in_mst [2];
    pkg_st::t_st      st [2];
    logic [7:0][31:0] buff0;
    logic [7:0][31:0] buff1;

    modport master (output en, in_mst, input st, buff0, buff1);
    modport slave  (input en, in_mst, output st, buff0, buff1);
endinterface

// File: rtl/xbar2x2_top.sv
// Two-master / two-slave memory subsystem.
//
// master    : single-word command engine, ADDR -> REQ -> DATA -> RESP -> ADDR.
// cross_bar : per-slave fixed-priority arbiter (master 0 wins ties) and router,
//             slave selected by addr[31].
// slave     : 16 x 32 memory indexed by addr[3:0].
// xbar2x2_top ports:
//   clk  single clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  xbar2x2_top_if.slave (en, in_mst in; st, buff0, buff1 out)

module master (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  pkg_mst::t_mst    in_mst,
    input  pkg_slv::t_slv    rd,
    input  logic             mx0,
    output logic [7:0][31:0] buff,
    output pkg_mst::t_mst    out_mst,
    output pkg_st::t_st      st
);
    import pkg_st::*;

    t_st        st_nxt;
    logic       capture;
    logic       armed;
    logic [2:0] rcnt;

    always_comb begin
        st_nxt  = st;
        capture = 1'b0;
        case (st)
            ADDR: begin
                // A held strobe only issues once; it must drop to re-arm.
                if (en && armed) begin
                    capture = 1'b1;
                    st_nxt  = REQ;
                end
            end
            REQ:     if (mx0) st_nxt = DATA;
            DATA:    st_nxt = RESP;
            RESP:    st_nxt = ADDR;
            default: st_nxt = ADDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ADDR;
        else     st <= st_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_mst <= '0;
            armed   <= 1'b1;
            rcnt    <= '0;
            buff    <= '0;
        end else begin
            if (!en)          armed <= 1'b1;
            else if (capture) armed <= 1'b0;

            if (capture) begin
                out_mst     <= in_mst;
                out_mst.vld <= 1'b1;
            end else if (st == RESP) begin
                out_mst.vld <= 1'b0;
                if (!out_mst.cmd) begin
                    buff[rcnt] <= rd.data;
                    rcnt       <= rcnt + 3'd1;
                end
            end
        end
    end
endmodule

module cross_bar (
    input  logic          clk,
    input  logic          rst,
    input  pkg_mst::t_mst mst_to_cross [2],
    output pkg_mst::t_mst cross_to_slv [2],
    input  pkg_slv::t_slv rd_to_cross  [2],
    output pkg_slv::t_slv rd_to_mst    [2],
    output logic          mx0,
    output logic          mx1,
    input  pkg_st::t_st   st0,
    input  pkg_st::t_st   st1
);
    import pkg_st::*;

    t_st        st_m [2];
    logic [1:0] tgt;        // target slave of each master
    logic [1:0] own_vld;    // per slave: currently owned
    logic [1:0] own_id;     // per slave: owning master
    logic [1:0] owns;       // per master: owns its target slave
    logic [1:0] req [2];    // req[s][m]

    assign st_m[0] = st0;
    assign st_m[1] = st1;
    assign tgt[0]  = mst_to_cross[0].addr[31];
    assign tgt[1]  = mst_to_cross[1].addr[31];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 2; m++) begin
                req[s][m] = (st_m[m] == REQ) && (tgt[m] == 1'(s));
            end
        end
    end

    // Release happens on the owner's RESP edge; a free slave is only granted
    // on a later edge, so a released slave is idle for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_vld <= '0;
            own_id  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (!own_vld[s]) begin
                    if (req[s][0]) begin
                        own_vld[s] <= 1'b1;
                        own_id[s]  <= 1'b0;
                    end else if (req[s][1]) begin
                        own_vld[s] <= 1'b1;
                        own_id[s]  <= 1'b1;
                    end
                end else if (st_m[own_id[s]] == RESP) begin
                    own_vld[s] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            owns[m] = own_vld[tgt[m]] && (own_id[tgt[m]] == 1'(m));
        end
    end

    assign mx0 = owns[0];
    assign mx1 = owns[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cross_to_slv[s] = '0;
            if (own_vld[s]) begin
                // The slave only acts in the owner's DATA cycle.
                cross_to_slv[s]     = mst_to_cross[own_id[s]];
                cross_to_slv[s].vld = (st_m[own_id[s]] == DATA);
            end
        end
        for (int m = 0; m < 2; m++) begin
            rd_to_mst[m] = '0;
            if (owns[m] && (st_m[m] == RESP)) rd_to_mst[m] = rd_to_cross[tgt[m]];
        end
    end
endmodule

module slave (
    input  logic          clk,
    input  logic          rst,
    input  pkg_mst::t_mst in_slv,
    output pkg_slv::t_slv rd
);
    logic [31:0] mem [16];
    logic        unused_addr_hi;

    // Only addr[3:0] selects a word; the upper bits were used for routing.
    assign unused_addr_hi = ^in_slv.addr[31:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rd <= '0;
        end else if (in_slv.vld) begin
            if (in_slv.cmd) mem[in_slv.addr[3:0]] <= in_slv.data;
            else            rd.data <= mem[in_slv.addr[3:0]];
        end
    end
endmodule

module xbar2x2_top (
    input logic          clk,
    input logic          rst,
    xbar2x2_top_if.slave bus
);
    pkg_mst::t_mst    out_mst      [2];
    pkg_mst::t_mst    cross_to_slv [2];
    pkg_slv::t_slv    rd_slv       [2];
    pkg_slv::t_slv    rd_mst       [2];
    pkg_st::t_st      st_w         [2];
    logic [7:0][31:0] buff_w       [2];
    logic [1:0]       mx_w;

    master u_mst0 (
        .clk(clk), .rst(rst), .en(bus.en[0]), .in_mst(bus.in_mst[0]),
        .rd(rd_mst[0]), .mx0(mx_w[0]), .buff(buff_w[0]),
        .out_mst(out_mst[0]), .st(st_w[0])
    );

    master u_mst1 (
        .clk(clk), .rst(rst), .en(bus.en[1]), .in_mst(bus.in_mst[1]),
        .rd(rd_mst[1]), .mx0(mx_w[1]), .buff(buff_w[1]),
        .out_mst(out_mst[1]), .st(st_w[1])
    );

    cross_bar u_xbar (
        .clk(clk), .rst(rst),
        .mst_to_cross(out_mst), .cross_to_slv(cross_to_slv),
        .rd_to_cross(rd_slv), .rd_to_mst(rd_mst),
        .mx0(mx_w[0]), .mx1(mx_w[1]),
        .st0(st_w[0]), .st1(st_w[1])
    );

    slave u_slv0 (.clk(clk), .rst(rst), .in_slv(cross_to_slv[0]), .rd(rd_slv[0]));
    slave u_slv1 (.clk(clk), .rst(rst), .in_slv(cross_to_slv[1]), .rd(rd_slv[1]));

    assign bus.st[0] = st_w[0];
    assign bus.st[1] = st_w[1];
    assign bus.buff0 = buff_w[0];
    assign bus.buff1 = buff_w[1];
endmodule

// File: tb/tb_xbar2x2_top.sv
// Testbench for xbar2x2_top: table-driven transaction vectors, hand-written
// timing sequences and randomized traffic checked against a reference model
// of slave memories, master buffers and spec-level latencies.
module tb_xbar2x2_top;
    import pkg_st::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xbar2x2_top_if bus();
    xbar2x2_top dut (.clk(clk), .rst(rst), .bus(bus));

    int nchk = 0;
    int nerr = 0;

    logic [31:0] mem_m [2][16];
    logic [31:0] buf_m [2][8];
    int          rcnt_m [2];

    typedef struct {
        logic        e0;
        logic        c0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        e1;
        logic        c1;
        logic [31:0] a1;
        logic [31:0] d1;
        int          x0;
        int          x1;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] s32(input t_st s);
        return {30'b0, s};
    endfunction

    function automatic vec_t mk(input logic e0, input logic c0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic e1, input logic c1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input int x0, input int x1);
        vec_t v;
        v.e0 = e0; v.c0 = c0; v.a0 = a0; v.d0 = d0;
        v.e1 = e1; v.c1 = c1; v.a1 = a1; v.d1 = d1;
        v.x0 = x0; v.x1 = x1;
        return v;
    endfunction

    // Spec-level latency: 4 cycles from capture, master 1 waits another 4
    // when both masters hit the same slave in the same cycle.
    function automatic int exp_lat(input int m, input vec_t v);
        if (m == 0) return v.e0 ? 4 : 0;
        if (!v.e1) return 0;
        return (v.e0 && (v.a0[31] == v.a1[31])) ? 8 : 4;
    endfunction

    // Expected state k edges after capture for a master granted at edge g.
    function automatic t_st exp_st(input int g, input int k);
        if (k <= g)     return REQ;
        if (k == g + 1) return DATA;
        if (k == g + 2) return RESP;
        return ADDR;
    endfunction

    task automatic mdl_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) mem_m[m][i] = '0;
            for (int i = 0; i < 8; i++)  buf_m[m][i] = '0;
            rcnt_m[m] = 0;
        end
    endtask

    task automatic mdl_op(input int m, input logic cmd, input logic [31:0] addr,
                          input logic [31:0] data);
        int s;
        int idx;
        s   = int'(addr[31]);
        idx = int'(addr[3:0]);
        if (cmd) mem_m[s][idx] = data;
        else begin
            buf_m[m][rcnt_m[m]] = mem_m[s][idx];
            rcnt_m[m] = (rcnt_m[m] + 1) % 8;
        end
    endtask

    task automatic run_pair(input vec_t v, input string tag);
        int d0 = 0;
        int d1 = 0;
        bus.in_mst[0] = '{vld: 1'b0, cmd: v.c0, addr: v.a0, data: v.d0};
        bus.in_mst[1] = '{vld: 1'b0, cmd: v.c1, addr: v.a1, data: v.d1};
        bus.en = {v.e1, v.e0};
        @(posedge clk); #1;
        bus.en = 2'b00;
        if (v.e0) mdl_op(0, v.c0, v.a0, v.d0);
        if (v.e1) mdl_op(1, v.c1, v.a1, v.d1);
        for (int k = 1; k <= 20 && ((v.e0 && d0 == 0) || (v.e1 && d1 == 0)); k++) begin
            @(posedge clk); #1;
            if (v.e0 && d0 == 0 && bus.st[0] == ADDR) d0 = k;
            if (v.e1 && d1 == 0 && bus.st[1] == ADDR) d1 = k;
        end
        if (v.e0) chk($sformatf("%s lat0", tag), 32'(d0), 32'(v.x0));
        if (v.e1) chk($sformatf("%s lat1", tag), 32'(d1), 32'(v.x1));
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) run_pair(tbl[i], $sformatf("%s[%0d]", tag, i));
        tbl.delete();
    endtask

    task automatic chk_bufs_const(input string tag, input logic [31:0] b0, input logic [31:0] s0,
                                  input logic [31:0] b1, input logic [31:0] s1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s buff0[%0d]", tag, k), bus.buff0[k], b0 + s0 * 32'(k));
            chk($sformatf("%s buff1[%0d]", tag, k), bus.buff1[k], b1 + s1 * 32'(k));
        end
    endtask

    task automatic chk_bufs_model(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s buff0[%0d]", tag, k), bus.buff0[k], buf_m[0][k]);
            chk($sformatf("%s buff1[%0d]", tag, k), bus.buff1[k], buf_m[1][k]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [1:0] e;

        rst = 1'b1;
        bus.en = 2'b00;
        bus.in_mst[0] = '0;
        bus.in_mst[1] = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset st0", s32(bus.st[0]), s32(ADDR));
        chk("reset st1", s32(bus.st[1]), s32(ADDR));
        chk_bufs_model("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Serialised traffic on slave 0.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) tbl.push_back(mk(1, 1, 32'(i), 32'h11 + 32'(i), 0, 0, 0, 0, 4, 0));
            else            tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'(i), 32'h11 + 32'(i), 0, 4));
        end
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) tbl.push_back(mk(1, 0, 32'(i), 0, 0, 0, 0, 0, 4, 0));
            else            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'(i), 0, 0, 4));
        end
        run_table("s0");
        chk_bufs_const("s0", 32'h11, 2, 32'h12, 2);

        // Same on slave 1.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) tbl.push_back(mk(1, 1, 32'h8000_0000 | i, 32'h11 + 32'(i), 0, 0, 0, 0, 4, 0));
            else            tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8000_0000 | i, 32'h11 + 32'(i), 0, 4));
        end
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) tbl.push_back(mk(1, 0, 32'h8000_0000 | i, 0, 0, 0, 0, 0, 4, 0));
            else            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h8000_0000 | i, 0, 0, 4));
        end
        run_table("s1");
        chk_bufs_const("s1", 32'h11, 2, 32'h12, 2);

        // Slave 0 still holds its own contents.
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 32'(i), 0, 0, 0, 0, 0, 4, 0));
        run_table("s0keep");
        chk_bufs_const("s0keep", 32'h11, 1, 32'h12, 2);

        // Parallel cross traffic, then swapped routing.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 32'(i), 32'h51 + 32'(i), 1, 1, 32'h8000_0000 | i, 32'ha1 + 32'(i), 4, 4));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 32'(i), 0, 1, 0, 32'h8000_0000 | i, 0, 4, 4));
        run_table("par");
        chk_bufs_const("par", 32'h51, 1, 32'ha1, 1);

        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 32'h8000_0000 | i, 32'h51 + 32'(i), 1, 1, 32'(i), 32'ha1 + 32'(i), 4, 4));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 32'h8000_0000 | i, 0, 1, 0, 32'(i), 0, 4, 4));
        run_table("swap");
        chk_bufs_const("swap", 32'h51, 1, 32'ha1, 1);

        // Contention: master 0 is served first, so ordering shows in the data.
        tbl.push_back(mk(1, 1, 32'd3, 32'hC0FF_EE01, 1, 0, 32'd3, 0, 4, 8));
        tbl.push_back(mk(1, 0, 32'h8000_0005, 0, 1, 1, 32'h8000_0005, 32'h5A5A_0001, 4, 8));
        tbl.push_back(mk(1, 0, 32'd7, 0, 1, 0, 32'h8000_0007, 0, 4, 4));
        run_table("cont");
        chk_bufs_model("cont");

        // Cycle-by-cycle contention trace on slave 0.
        bus.in_mst[0] = '{vld: 1'b0, cmd: 1'b0, addr: 32'd0, data: 32'd0};
        bus.in_mst[1] = '{vld: 1'b0, cmd: 1'b0, addr: 32'd1, data: 32'd0};
        bus.en = 2'b11;
        @(posedge clk); #1;
        bus.en = 2'b00;
        mdl_op(0, 1'b0, 32'd0, 32'd0);
        mdl_op(1, 1'b0, 32'd1, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("trace st0 k%0d", k), s32(bus.st[0]), s32(exp_st(1, k)));
            chk($sformatf("trace st1 k%0d", k), s32(bus.st[1]), s32(exp_st(5, k)));
        end
        chk_bufs_model("trace");

        // Held strobe issues only once.
        bus.in_mst[0] = '{vld: 1'b0, cmd: 1'b0, addr: 32'h8000_0002, data: 32'd0};
        bus.en = 2'b01;
        @(posedge clk); #1;
        mdl_op(0, 1'b0, 32'h8000_0002, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held st0 k%0d", k), s32(bus.st[0]), s32(exp_st(1, k)));
        end
        bus.en = 2'b00;
        @(posedge clk); #1;

        // Strobe while busy, dropped before return: ignored.
        bus.in_mst[0] = '{vld: 1'b0, cmd: 1'b0, addr: 32'd9, data: 32'd0};
        bus.en = 2'b01;
        @(posedge clk); #1;  bus.en = 2'b00;
        mdl_op(0, 1'b0, 32'd9, 32'd0);
        @(posedge clk); #1;  bus.en = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;  bus.en = 2'b00;
        @(posedge clk); #1;  chk("busy1 st0 E4", s32(bus.st[0]), s32(ADDR));
        @(posedge clk); #1;  chk("busy1 st0 E5", s32(bus.st[0]), s32(ADDR));

        // Strobe while busy, still high on return: re-issued.
        bus.en = 2'b01;
        @(posedge clk); #1;  bus.en = 2'b00;
        mdl_op(0, 1'b0, 32'd9, 32'd0);
        @(posedge clk); #1;  bus.en = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;  chk("busy2 st0 E4", s32(bus.st[0]), s32(ADDR));
        @(posedge clk); #1;  chk("busy2 st0 E5", s32(bus.st[0]), s32(REQ));
        bus.en = 2'b00;
        mdl_op(0, 1'b0, 32'd9, 32'd0);
        for (int k = 6; k <= 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("busy2 st0 k%0d", k), s32(bus.st[0]), s32(exp_st(6, k)));
        end
        chk_bufs_model("busy");

        // Asynchronous reset in the DATA cycle of a write.
        bus.in_mst[0] = '{vld: 1'b0, cmd: 1'b1, addr: 32'd5, data: 32'hDEAD_BEEF};
        bus.en = 2'b01;
        @(posedge clk); #1;  bus.en = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;  chk("rstmid st0 DATA", s32(bus.st[0]), s32(DATA));
        rst = 1'b1;
        #1;
        mdl_reset();
        chk("rstmid st0", s32(bus.st[0]), s32(ADDR));
        chk("rstmid st1", s32(bus.st[1]), s32(ADDR));
        chk_bufs_model("rstmid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_pair(mk(1, 0, 32'd5, 0, 1, 0, 32'd3, 0, 4, 8), "rstrd");
        chk_bufs_model("rstrd");

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            e = 2'($urandom_range(1, 3));
            v.e0 = e[0];
            v.c0 = 1'($urandom_range(0, 1));
            v.a0 = {1'($urandom_range(0, 1)), 27'($urandom), 4'($urandom)};
            v.d0 = $urandom;
            v.e1 = e[1];
            v.c1 = 1'($urandom_range(0, 1));
            v.a1 = {1'($urandom_range(0, 1)), 27'($urandom), 4'($urandom)};
            v.d1 = $urandom;
            v.x0 = exp_lat(0, v);
            v.x1 = exp_lat(1, v);
            run_pair(v, $sformatf("rnd%0d", n));
        end
        chk_bufs_model("rnd");

        // Read back every word of both slaves through master 0.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                run_pair(mk(1, 0, {s[0], 27'($urandom), 4'(i)}, 0, 0, 0, 0, 0, 4, 0),
                         $sformatf("dump%0d_%0d", s, i));
                if (i % 8 == 7) chk_bufs_model($sformatf("dump%0d_%0d", s, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
